morph_window_ctrl: RTL

MORPH_WINDOW_CTRL -- requirements
Module: morph_window_ctrl

---
 rtl/morph_pkg.sv | 16 +
 rtl/raster_counter.sv | 35 +++
 rtl/morph_window_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/morph_pkg.sv
// morph_pkg: shared state encoding, pad value and window tap masks for the morphology window controller
package morph_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_FLUSH = 2'd3;
  localparam logic [9:0] PAD_VALUE = 10'h3FF;
  localparam logic [8:0] TAPS_TOP   = 9'b000_000_111;
  localparam logic [8:0] TAPS_BOT   = 9'b111_000_000;
  localparam logic [8:0] TAPS_LEFT  = 9'b001_001_001;
  localparam logic [8:0] TAPS_RIGHT = 9'b100_100_100;
  function automatic logic [8:0] edge_mask(input logic top, input logic bot, input logic left, input logic right);
    return (top ? TAPS_TOP : 9'd0) | (bot ? TAPS_BOT : 9'd0) | (left ? TAPS_LEFT : 9'd0) | (right ? TAPS_RIGHT : 9'd0);
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: tracks the (cy,cx) coordinate of the next window centre in raster order
module raster_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW = $clog2(IMG_W),
  parameter int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_i,
  output logic [XW-1:0] cx_o,
  output logic [YW-1:0] cy_o,
  output logic          eol_o,
  output logic          eof_o
);
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;
  assign cx_o  = cx_q;
  assign cy_o  = cy_q;
  assign eol_o = cx_q == XW'(IMG_W - 1);
  assign eof_o = eol_o && cy_q == YW'(IMG_H - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (clr_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (step_i) begin
      cx_q <= eol_o ? '0 : cx_q + 1'b1;
      cy_q <= eof_o ? '0 : eol_o ? cy_q + 1'b1 : cy_q;
    end
  end
endmodule

// File: rtl/morph_window_ctrl.sv
// morph_window_ctrl: sequences line-buffer shifts, pad flushing and 3x3 window valid/mask for a raster morphology filter
module morph_window_ctrl
  import morph_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic       lb_clken,
  output logic       pad_sel,
  output logic       win_valid,
  output logic [8:0] win_mask,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       busy,
  output logic       frame_err
);
  localparam int CW = $clog2(IMG_W * IMG_H + IMG_W + 2);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [CW-1:0] FILL_END   = CW'(IMG_W + 2);
  localparam logic [CW-1:0] LAST_PIX   = CW'(IMG_W * IMG_H);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(IMG_W * IMG_H + IMG_W + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, in_frame, start, restart, centre;
  logic          win_valid_q, frame_err_q;
  logic [8:0]    win_mask_q;
  logic [2:0]    flags_q;
  logic [3:0]    pipe_q [PIPE_LAT];
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          eol, eof;

  assign in_ready = state_q != ST_FLUSH;
  assign pad_sel  = state_q == ST_FLUSH;
  assign busy     = state_q != ST_IDLE;
  assign accept   = in_valid & in_ready;
  assign in_frame = state_q == ST_FILL || state_q == ST_RUN;
  assign start    = accept & in_sof & (state_q == ST_IDLE);
  assign restart  = accept & in_sof & in_frame;
  assign lb_clken = pad_sel | start | (accept & in_frame);
  assign cnt_d    = (start | restart) ? CW'(1) : lb_clken ? cnt_q + 1'b1 : cnt_q;
  // Shift n puts centre n-(IMG_W+2) into the window; a (re)start shift never does.
  assign centre   = lb_clken & ~(start | restart) & (cnt_d >= FILL_END);

  always_comb begin
    state_d = state_q;
    if (start | restart) state_d = ST_FILL;
    else if (state_q == ST_FILL && accept && cnt_d == FILL_END) state_d = ST_RUN;
    else if (state_q == ST_RUN && accept && cnt_d == LAST_PIX) state_d = ST_FLUSH;
    else if (state_q == ST_FLUSH && cnt_d == LAST_SHIFT) state_d = ST_IDLE;
  end

  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW)) u_raster (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start | restart),
    .step_i(centre),
    .cx_o  (cx),
    .cy_o  (cy),
    .eol_o (eol),
    .eof_o (eof)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      win_mask_q  <= '0;
      flags_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_valid_q <= centre;
      win_mask_q  <= centre ? edge_mask(cy == '0, cy == YW'(IMG_H - 1), cx == '0, eol) : '0;
      flags_q     <= centre ? {cx == '0 && cy == '0, eol, eof} : '0;
      frame_err_q <= restart;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {win_valid_q, flags_q};
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign win_valid = win_valid_q;
  assign win_mask  = win_mask_q;
  assign frame_err = frame_err_q;
  assign {out_valid, out_sof, out_eol, out_eof} = pipe_q[PIPE_LAT-1];
endmodule
